// File: rtl/store_image_if.sv
// Bundle for the store_image block: job control, the pixel input stream and the
// DMA write port. The slave modport is the block side; master is the environment side.
interface store_image_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 20
);
  logic                  start;
  logic [5:0]            imgSize;
  logic [ADDR_WIDTH-1:0] initialAddr;
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_ready;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic [DATA_WIDTH-1:0] mem_data;
  logic                  mem_ack;
  logic                  busy;
  logic                  done;

  modport slave (
    input  start, imgSize, initialAddr, in_valid, in_data, mem_ack,
    output in_ready, mem_we, mem_address, mem_data, busy, done
  );

  modport master (
    output start, imgSize, initialAddr, in_valid, in_data, mem_ack,
    input  in_ready, mem_we, mem_address, mem_data, busy, done
  );
endinterface

// File: rtl/store_image.sv
// Write-back engine: buffers a row-major pixel stream in a small FIFO and writes
// size*size words to consecutive memory addresses through the DMA write port.
module store_image #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 20,
  parameter int FIFO_DEPTH = 8,
  parameter int MAX_SIZE   = 32
) (
  input  logic          clk,
  input  logic          rst,
  store_image_if.slave  bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FINISH
  } state_t;

  state_t                state_q, state_d;
  logic [10:0]           total_q, total_d;
  logic [10:0]           accepted_q, accepted_d;
  logic [10:0]           written_q, written_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [PTR_W:0]        wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]        rd_ptr_q, rd_ptr_d;

  logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];

  logic [5:0]            size_c;
  logic [10:0]           size_ext_c;
  logic [10:0]           total_c;
  logic                  fifo_empty_c;
  logic                  fifo_full_c;
  logic                  run_c;
  logic                  in_ready_c;
  logic                  mem_we_c;
  logic                  push_c;
  logic                  pop_c;

  // Oversized images are clamped; 32*32 = 1024 still fits the 11-bit total.
  assign size_c     = (bus.imgSize > 6'(MAX_SIZE)) ? 6'(MAX_SIZE) : bus.imgSize;
  assign size_ext_c = {5'b0, size_c};
  assign total_c    = size_ext_c * size_ext_c;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign fifo_empty_c = (wr_ptr_q == rd_ptr_q);
  assign fifo_full_c  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                        (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);

  // in_ready depends on registered state only, so a same-cycle pop never frees a full FIFO.
  assign run_c      = (state_q == ST_RUN);
  assign in_ready_c = run_c && !fifo_full_c && (accepted_q < total_q);
  assign mem_we_c   = run_c && !fifo_empty_c;
  assign push_c     = bus.in_valid && in_ready_c;
  assign pop_c      = mem_we_c && bus.mem_ack;

  always_comb begin
    state_d    = state_q;
    total_d    = total_q;
    accepted_d = accepted_q;
    written_d  = written_q;
    addr_d     = addr_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          total_d    = total_c;
          addr_d     = bus.initialAddr;
          accepted_d = '0;
          written_d  = '0;
          wr_ptr_d   = '0;
          rd_ptr_d   = '0;
          state_d    = (total_c == 11'd0) ? ST_FINISH : ST_RUN;
        end
      end
      ST_RUN: begin
        if (push_c) begin
          accepted_d = accepted_q + 11'd1;
          wr_ptr_d   = wr_ptr_q + (PTR_W+1)'(1);
        end
        if (pop_c) begin
          written_d = written_q + 11'd1;
          addr_d    = addr_q + ADDR_WIDTH'(1);
          rd_ptr_d  = rd_ptr_q + (PTR_W+1)'(1);
        end
        // All words accepted have been written by now, so the FIFO is already empty.
        if (written_q == total_q) begin
          state_d = ST_FINISH;
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      total_q    <= '0;
      accepted_q <= '0;
      written_q  <= '0;
      addr_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      total_q    <= total_d;
      accepted_q <= accepted_d;
      written_q  <= written_d;
      addr_q     <= addr_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // Storage needs no reset: entries are only read between a push and its pop.
  always_ff @(posedge clk) begin
    if (push_c) begin
      fifo_mem[wr_ptr_q[PTR_W-1:0]] <= bus.in_data;
    end
  end

  assign bus.in_ready    = in_ready_c;
  assign bus.mem_we      = mem_we_c;
  assign bus.mem_address = addr_q;
  // Masked so stale FIFO contents never show up on the bus when idle or after reset.
  assign bus.mem_data    = mem_we_c ? fifo_mem[rd_ptr_q[PTR_W-1:0]] : '0;
  assign bus.busy        = run_c;
  assign bus.done        = (state_q == ST_FINISH);
endmodule

// File: tb/tb_store_image.sv
// Directed bench for store_image: a driver issues jobs and queues the expected
// (address, data) writes; a negedge monitor pops and compares each completed write.
module tb_store_image;
  localparam int DW    = 16;
  localparam int AW    = 20;
  localparam int DEPTH = 8;

  logic clk;
  logic rst;

  store_image_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  store_image #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .FIFO_DEPTH(DEPTH),
    .MAX_SIZE(32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [AW+DW-1:0] exp_q[$];
  logic [AW+DW-1:0] exp_e;
  int               written  = 0;
  int               done_cnt = 0;
  logic             prev_done = 1'b0;
  logic             hold_pending = 1'b0;
  logic [AW-1:0]    hold_addr;
  logic [DW-1:0]    hold_data;

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: scoreboard pop on every completed write, plus hold and done-pulse checks.
  always @(negedge clk) begin
    if (rst) begin
      hold_pending = 1'b0;
      prev_done    = 1'b0;
    end else begin
      if (hold_pending) begin
        chk(bus.mem_we == 1'b1, "hold_we", 64'(bus.mem_we), 64'd1);
        chk(bus.mem_address == hold_addr, "hold_addr", 64'(bus.mem_address), 64'(hold_addr));
        chk(bus.mem_data == hold_data, "hold_data", 64'(bus.mem_data), 64'(hold_data));
      end
      hold_pending = bus.mem_we && !bus.mem_ack;
      hold_addr    = bus.mem_address;
      hold_data    = bus.mem_data;
      if (bus.mem_we && bus.mem_ack) begin
        if (exp_q.size() == 0) begin
          chk(1'b0, "unexpected_write", 64'(bus.mem_address), 64'd0);
        end else begin
          exp_e = exp_q.pop_front();
          chk(bus.mem_address == exp_e[AW+DW-1:DW], "wr_addr", 64'(bus.mem_address), 64'(exp_e[AW+DW-1:DW]));
          chk(bus.mem_data == exp_e[DW-1:0], "wr_data", 64'(bus.mem_data), 64'(exp_e[DW-1:0]));
        end
        written++;
      end
      if (bus.done) begin
        chk(bus.busy == 1'b0, "busy_at_done", 64'(bus.busy), 64'd0);
        chk(prev_done == 1'b0, "done_width", 64'(prev_done), 64'd0);
        done_cnt++;
      end
      prev_done = bus.done;
    end
  end

  // One job: queue expected writes, pulse start, stream pixels with in_valid held high.
  // ack_mode 0: ack always; 1: ack every 3rd cycle. ss_at: cycle of an extra start.
  // abort_at: assert rst once this many writes have completed (-1 = never).
  task automatic run_job(input int sz, input logic [AW-1:0] a0, input logic [DW-1:0] base,
                         input int ack_mode, input int ss_at, input int abort_at,
                         input int extra, output int done_k);
    int total;
    int eff;
    int idx;
    int k;
    int done_before;
    logic exp_rdy;
    eff    = (sz > 32) ? 32 : sz;
    total  = eff * eff;
    done_k = -1;
    for (int i = 0; i < total; i++) begin
      exp_q.push_back({a0 + AW'(i), base + DW'(i)});
    end
    done_before = done_cnt;
    @(posedge clk); #1;
    written          = 0;
    bus.start        = 1'b1;
    bus.imgSize      = 6'(sz);
    bus.initialAddr  = a0;
    bus.in_valid     = 1'b0;
    bus.mem_ack      = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    idx = 0;
    k   = 0;
    while (k < 5000) begin
      exp_rdy = (idx < total) && ((idx - written) < DEPTH);
      chk(bus.in_ready == exp_rdy, "in_ready", 64'(bus.in_ready), 64'(exp_rdy));
      if (bus.done && done_k < 0) done_k = k;
      if (done_k >= 0 && k >= done_k + extra) break;
      if (abort_at >= 0 && written == abort_at) begin
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.mem_ack  = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        chk(bus.in_ready == 1'b0, "abort_in_ready", 64'(bus.in_ready), 64'd0);
        chk(bus.mem_we == 1'b0, "abort_mem_we", 64'(bus.mem_we), 64'd0);
        chk(bus.busy == 1'b0, "abort_busy", 64'(bus.busy), 64'd0);
        chk(bus.done == 1'b0, "abort_done", 64'(bus.done), 64'd0);
        chk(bus.mem_address == '0, "abort_addr", 64'(bus.mem_address), 64'd0);
        chk(bus.mem_data == '0, "abort_data", 64'(bus.mem_data), 64'd0);
        exp_q.delete();
        repeat (6) @(posedge clk);
        #1;
        chk(done_cnt == done_before, "abort_no_done", 64'(done_cnt), 64'(done_before));
        $display("job size=%0d addr=%0h aborted after %0d writes", sz, a0, written);
        return;
      end
      bus.start = (k == ss_at);
      if (k == ss_at) begin
        bus.imgSize     = 6'd5;
        bus.initialAddr = 20'h90000;
      end
      bus.mem_ack  = (ack_mode == 0) ? 1'b1 : ((k % 3) == 0);
      bus.in_valid = 1'b1;
      bus.in_data  = (idx < total) ? base + DW'(idx) : 16'hDEAD;
      if (bus.in_ready) idx++;
      @(posedge clk); #1;
      k++;
    end
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    bus.mem_ack  = 1'b0;
    chk(done_k >= 0, "done_timeout", 64'(done_k), 64'd0);
    chk(written == total, "write_count", 64'(written), 64'(total));
    chk(exp_q.size() == 0, "queue_drained", 64'(exp_q.size()), 64'd0);
    chk(done_cnt == done_before + 1, "done_once", 64'(done_cnt - done_before), 64'd1);
    exp_q.delete();
    $display("job size=%0d addr=%0h writes=%0d done_cycle=%0d", sz, a0, written, done_k);
  endtask

  int dk;

  initial begin
    rst             = 1'b1;
    bus.start       = 1'b0;
    bus.imgSize     = '0;
    bus.initialAddr = '0;
    bus.in_valid    = 1'b0;
    bus.in_data     = '0;
    bus.mem_ack     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk(bus.in_ready == 1'b0, "rst_in_ready", 64'(bus.in_ready), 64'd0);
    chk(bus.mem_we == 1'b0, "rst_mem_we", 64'(bus.mem_we), 64'd0);
    chk(bus.busy == 1'b0, "rst_busy", 64'(bus.busy), 64'd0);
    chk(bus.done == 1'b0, "rst_done", 64'(bus.done), 64'd0);
    chk(bus.mem_address == '0, "rst_addr", 64'(bus.mem_address), 64'd0);
    chk(bus.mem_data == '0, "rst_data", 64'(bus.mem_data), 64'd0);

    // 16 words at full rate: last push at cycle 16, last write at 17, done at 18.
    run_job(4, 20'h00100, 16'h0000, 0, -1, -1, 2, dk);
    chk(dk == 18, "t1_done_cycle", 64'(dk), 64'd18);

    run_job(32, 20'h02000, 16'h1000, 1, -1, -1, 2, dk);
    run_job(2, 20'hFFFFE, 16'h0055, 0, -1, -1, 2, dk);

    run_job(0, 20'h00300, 16'h0000, 0, -1, -1, 2, dk);
    chk(dk >= 0 && dk <= 2, "t4_zero_done", 64'(dk), 64'd0);
    run_job(40, 20'h04000, 16'h7000, 0, -1, -1, 2, dk);

    // Extra start mid-job and in_valid held high for 6 cycles after done.
    run_job(3, 20'h00500, 16'h0300, 0, 4, -1, 6, dk);

    run_job(4, 20'h00600, 16'h0600, 0, -1, 5, 2, dk);
    run_job(4, 20'h00700, 16'h0800, 1, -1, -1, 2, dk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
